// File: rtl/matrix_mult_ctrl.sv
// Sequences an NxN signed matrix multiply over two read-only matrix RAMs; one MAC per cycle, results row-major.
// Latency N+2 cycles per element; c_ready low holds EMIT with the RAMs idle, one cycle per stalled cycle.
module matrix_mult_ctrl #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int ADDRESS_BITS = 2,
    localparam int ACC_WIDTH    = 2*DATA_WIDTH+ADDRESS_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    a_enable_n,
    output logic                    b_enable_n,
    output logic                    a_wren_n,
    output logic                    b_wren_n,
    output logic [ADDRESS_BITS-1:0] a_address,
    output logic [ADDRESS_BITS-1:0] b_address,
    output logic [2:0]              a_byteena,
    output logic [2:0]              b_byteena,
    input  logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [ACC_WIDTH-1:0]    c_data,
    output logic [ADDRESS_BITS-1:0] c_row,
    output logic [ADDRESS_BITS-1:0] c_col
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDRESS_BITS-1:0] LAST = '1;
    localparam logic [ADDRESS_BITS-1:0] ONE  = ADDRESS_BITS'(1);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [ADDRESS_BITS-1:0]        r_i;
    logic [ADDRESS_BITS-1:0]        r_j;
    logic [ADDRESS_BITS-1:0]        r_k;
    logic                           r_acc_vld;
    logic                           r_acc_first;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    r_c_data;
    logic [ADDRESS_BITS-1:0]        r_c_row;
    logic [ADDRESS_BITS-1:0]        r_c_col;

    logic                           w_hs;
    logic                           w_last_elem;
    logic signed [2*DATA_WIDTH-1:0] w_a_ext;
    logic signed [2*DATA_WIDTH-1:0] w_b_ext;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_acc_next;

    assign w_hs        = (r_state == S_EMIT) && c_ready;
    assign w_last_elem = (r_i == LAST) && (r_j == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_FETCH;
            S_FETCH: if (r_k == LAST) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_EMIT;
            S_EMIT:  if (c_ready) w_state_next = w_last_elem ? S_DONE : S_FETCH;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = 1'b1;
        done       = 1'b0;
        a_enable_n = 1'b1;
        b_enable_n = 1'b1;
        c_valid    = 1'b0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_FETCH: begin
                a_enable_n = 1'b0;
                b_enable_n = 1'b0;
            end
            S_EMIT:  c_valid = 1'b1;
            S_DONE:  done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_k != LAST) r_k <= r_k + ONE;
                end
                S_EMIT: begin
                    if (w_hs && !w_last_elem) begin
                        r_k <= '0;
                        r_j <= r_j + ONE;
                        if (r_j == LAST) r_i <= r_i + ONE;
                    end
                end
                default: r_k <= r_k;
            endcase
        end
    end

    assign w_a_ext    = {{DATA_WIDTH{a_rdata[DATA_WIDTH-1]}}, a_rdata};
    assign w_b_ext    = {{DATA_WIDTH{b_rdata[DATA_WIDTH-1]}}, b_rdata};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{ADDRESS_BITS{w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign w_acc_next = r_acc_first ? w_prod_ext : r_acc + w_prod_ext;

    // The last product lands in DRAIN, so the result register captures the final sum there
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_vld   <= 1'b0;
            r_acc_first <= 1'b0;
            r_acc       <= '0;
            r_c_data    <= '0;
            r_c_row     <= '0;
            r_c_col     <= '0;
        end else begin
            r_acc_vld   <= (r_state == S_FETCH);
            r_acc_first <= (r_k == '0);
            if (r_acc_vld) r_acc <= w_acc_next;
            if (r_state == S_DRAIN) begin
                r_c_data <= w_acc_next;
                r_c_row  <= r_i;
                r_c_col  <= r_j;
            end
        end
    end

    assign a_wren_n  = 1'b1;
    assign b_wren_n  = 1'b1;
    assign a_address = r_i;
    assign a_byteena = 3'(r_k);
    assign b_address = r_k;
    assign b_byteena = 3'(r_j);
    assign c_data    = r_c_data;
    assign c_row     = r_c_row;
    assign c_col     = r_c_col;

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Bench for matrix_mult_ctrl: behavioural RAMs, model-fed scoreboard, table of matrix pairs plus stall/start/reset sequences.
module tb_matrix_mult_ctrl;

    localparam int DW = 8;
    localparam int AB = 2;
    localparam int N  = 4;
    localparam int AW = 2*DW+AB;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          a_enable_n;
    logic          b_enable_n;
    logic          a_wren_n;
    logic          b_wren_n;
    logic [AB-1:0] a_address;
    logic [AB-1:0] b_address;
    logic [2:0]    a_byteena;
    logic [2:0]    b_byteena;
    logic [DW-1:0] a_rdata;
    logic [DW-1:0] b_rdata;
    logic          c_valid;
    logic          c_ready;
    logic [AW-1:0] c_data;
    logic [AB-1:0] c_row;
    logic [AB-1:0] c_col;

    matrix_mult_ctrl #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .a_enable_n(a_enable_n), .b_enable_n(b_enable_n),
        .a_wren_n(a_wren_n), .b_wren_n(b_wren_n),
        .a_address(a_address), .b_address(b_address),
        .a_byteena(a_byteena), .b_byteena(b_byteena),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .c_row(c_row), .c_col(c_col)
    );

    typedef struct {
        logic signed [DW-1:0] a [N][N];
        logic signed [DW-1:0] b [N][N];
        int exp_c00;
        int exp_first;
        int exp_done;
    } vec_t;

    typedef struct {
        int data;
        int row;
        int col;
    } exp_t;

    vec_t tbl [3];
    exp_t exp_q [$];

    logic signed [DW-1:0] mem_a [N][8];
    logic signed [DW-1:0] mem_b [N][8];

    int cyc = 0;
    int s = 0;
    int checks = 0;
    int errors = 0;
    int first_v, first_data, hs_cnt, done_cnt, done_cyc, last_busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Read-only RAM model: registered output, one-cycle latency
    always @(posedge clk) begin
        if (!a_enable_n) a_rdata <= mem_a[a_address][a_byteena];
        if (!b_enable_n) b_rdata <= mem_b[b_address][b_byteena];
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (c_valid && first_v < 0) first_v = cyc - s;
        if (c_valid && c_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got data=%0d row=%0d col=%0d, required no result", $signed(c_data), c_row, c_col);
            end else begin
                e = exp_q.pop_front();
                if ($signed(c_data) !== e.data || c_row !== e.row[AB-1:0] || c_col !== e.col[AB-1:0]) begin
                    errors++;
                    $display("FAIL scoreboard: got data=%0d row=%0d col=%0d, required data=%0d row=%0d col=%0d",
                             $signed(c_data), c_row, c_col, e.data, e.row, e.col);
                end
            end
            if (hs_cnt == 0) first_data = $signed(c_data);
            hs_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc - s;
        end
        if (busy) last_busy = cyc - s;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_reset(input string name);
        logic [38:0] act;
        logic [38:0] req;
        act = {busy, done, c_valid, a_enable_n, b_enable_n, a_wren_n, b_wren_n,
               a_address, b_address, a_byteena, b_byteena, c_data, c_row, c_col};
        req = {7'b0001111, 32'h0};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got outputs %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < s + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input int v);
        int acc;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < 8; c++) begin
                mem_a[r][c] = (c < N) ? tbl[v].a[r][c] : 8'sd0;
                mem_b[r][c] = (c < N) ? tbl[v].b[r][c] : 8'sd0;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++) acc += int'(tbl[v].a[i][k]) * int'(tbl[v].b[k][j]);
                exp_q.push_back('{data: acc, row: i, col: j});
            end
        end
        @(posedge clk);
        #2;
        first_v = -1; first_data = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_busy = -1;
        start = 1'b1;
        s = cyc;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done pulse in %0d cycles, required one", name, n);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [AW-1:0] h_data;
        logic [AB-1:0] h_row;
        logic [AB-1:0] h_col;

        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                tbl[0].a[r][c] = (r == c) ? 8'sd1 : 8'sd0;
                tbl[0].b[r][c] = 8'(4*r + c);
                tbl[1].a[r][c] = 8'sh80;
                tbl[1].b[r][c] = 8'sh80;
                tbl[2].a[r][c] = 8'($urandom_range(0, 255));
                tbl[2].b[r][c] = 8'($urandom_range(0, 255));
            end
        end
        tbl[2].a[0][0] = 8'sd1;  tbl[2].a[0][1] = -8'sd2; tbl[2].a[0][2] = 8'sd3;  tbl[2].a[0][3] = -8'sd4;
        tbl[2].b[0][0] = 8'sd5;  tbl[2].b[1][0] = 8'sd6;  tbl[2].b[2][0] = -8'sd7; tbl[2].b[3][0] = 8'sd8;
        tbl[0].exp_c00 = 0;
        tbl[1].exp_c00 = 65536;
        tbl[2].exp_c00 = -60;
        for (int v = 0; v < 3; v++) begin
            tbl[v].exp_first = N + 2;
            tbl[v].exp_done  = N*N*(N+2) + 1;
        end

        first_v = -1; first_data = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_busy = -1;
        a_rdata = '0; b_rdata = '0;
        rst = 1'b1; start = 1'b0; c_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset_values");
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            start_run(v);
            wait_done($sformatf("vec%0d", v));
            check($sformatf("vec%0d_c00", v), first_data, tbl[v].exp_c00);
            check($sformatf("vec%0d_first_valid_cycle", v), first_v, tbl[v].exp_first);
            check($sformatf("vec%0d_done_cycle", v), done_cyc, tbl[v].exp_done);
            check($sformatf("vec%0d_last_busy_cycle", v), last_busy, tbl[v].exp_done);
            check($sformatf("vec%0d_results", v), hs_cnt, N*N);
            check($sformatf("vec%0d_done_pulses", v), done_cnt, 1);
            check($sformatf("vec%0d_leftover", v), exp_q.size(), 0);
        end

        // Three-cycle stall on C[1][2] (element 6, EMIT at cycle 6+6*6)
        start_run(0);
        wait_cycle(42);
        c_ready = 1'b0;
        h_data = '0; h_row = '0; h_col = '0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (t == 0) begin
                h_data = c_data; h_row = c_row; h_col = c_col;
                check("stall_row", int'(c_row), 1);
                check("stall_col", int'(c_col), 2);
                check("stall_data", int'($signed(c_data)), 6);
            end else begin
                check($sformatf("stall%0d_data_stable", t), int'($signed(c_data)), int'($signed(h_data)));
                check($sformatf("stall%0d_rowcol_stable", t), int'({c_row, c_col}), int'({h_row, h_col}));
            end
            check($sformatf("stall%0d_valid", t), int'(c_valid), 1);
            check($sformatf("stall%0d_enables", t), int'({a_enable_n, b_enable_n}), 3);
        end
        @(posedge clk);
        #2;
        c_ready = 1'b1;
        wait_done("stall");
        check("stall_done_cycle", done_cyc, N*N*(N+2) + 1 + 3);
        check("stall_results", hs_cnt, N*N);

        // start pulse mid-run is ignored
        start_run(1);
        wait_cycle(20);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_pulse");
        repeat (10) @(posedge clk);
        #2;
        check("start_pulse_results", hs_cnt, N*N);
        check("start_pulse_done_pulses", done_cnt, 1);
        check("start_pulse_done_cycle", done_cyc, N*N*(N+2) + 1);

        // Reset during FETCH of C[2][1] (element 9, FETCH cycles 55..58)
        start_run(2);
        wait_cycle(56);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("midrun_reset_values");
        check("midrun_results_before_reset", hs_cnt, 9);
        exp_q.delete();
        repeat (150) @(posedge clk);
        #2;
        check("midrun_no_done", done_cnt, 0);

        start_run(2);
        wait_done("after_reset");
        check("after_reset_c00", first_data, -60);
        check("after_reset_results", hs_cnt, N*N);
        check("after_reset_done_cycle", done_cyc, N*N*(N+2) + 1);
        check("after_reset_leftover", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
